// File: rtl/rcu_param.sv
// rcu_param: parameterised receiver control unit for the UART receive path.
// Sequences start-bit clear, bit timing, stop-bit check and RX buffer load,
// with a receive timeout, back-to-back packet acceptance and saturating
// statistics counters.
// Optional feature macro RCU_PARITY_EN: when defined, parity_error drops the
// packet in CHECK and counts into perr_cnt; when undefined, parity_error is
// ignored and perr_cnt is tied to zero.
module rcu_param #(
  parameter int TIMEOUT_CYC = 1000,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             new_packet_detected,
  input  logic             packet_done,
  input  logic             framing_error,
  input  logic             parity_error,
  input  logic             clear_stats,
  output logic             sbc_clear,
  output logic             sbc_enable,
  output logic             enable_timer,
  output logic             load_buffer,
  output logic             busy,
  output logic             timeout,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] ferr_cnt,
  output logic [CNT_W-1:0] perr_cnt,
  output logic [CNT_W-1:0] tout_cnt
);

  localparam int            TW    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    RECEIVE = 3'd2,
    STOP    = 3'd3,
    CHECK   = 3'd4,
    LOAD    = 3'd5
  } state_t;

  state_t          state_r;
  state_t          state_nx_s;
  logic [TW-1:0]   tcnt_r;
  logic            tout_hit_s;
  logic            err_s;
  logic            inc_pkt_s;
  logic            inc_ferr_s;
  logic            inc_tout_s;

  // Saturating increment shared by all statistics counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_W'(1);
    end
  endfunction

  // Moore output decode {sbc_clear, sbc_enable, enable_timer, load_buffer}.
  function automatic logic [3:0] moore_dec(input state_t s);
    case (s)
      CLEAR:   moore_dec = 4'b1000;
      STOP:    moore_dec = 4'b0100;
      RECEIVE: moore_dec = 4'b0010;
      LOAD:    moore_dec = 4'b0001;
      default: moore_dec = 4'b0000;
    endcase
  endfunction

`ifdef RCU_PARITY_EN
  assign err_s = framing_error | parity_error;
`else
  logic unused_parity_s;
  assign unused_parity_s = parity_error;
  assign err_s           = framing_error;
`endif

  assign tout_hit_s = (tcnt_r == TLAST);
  // packet_done has priority over the timeout in the same cycle
  assign inc_tout_s = (state_r == RECEIVE) && !packet_done && tout_hit_s;
  assign inc_pkt_s  = (state_r == CHECK) && !err_s;
  assign inc_ferr_s = (state_r == CHECK) && framing_error;

  // Next-state selection for the packet sequencer.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (new_packet_detected) state_nx_s = CLEAR;
        else                     state_nx_s = IDLE;
      end
      CLEAR:   state_nx_s = RECEIVE;
      RECEIVE: begin
        if (packet_done)     state_nx_s = STOP;
        else if (tout_hit_s) state_nx_s = IDLE;
        else                 state_nx_s = RECEIVE;
      end
      STOP:    state_nx_s = CHECK;
      CHECK: begin
        if (err_s) state_nx_s = IDLE;
        else       state_nx_s = LOAD;
      end
      LOAD: begin
        if (new_packet_detected) state_nx_s = CLEAR;
        else                     state_nx_s = IDLE;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State register, registered Moore outputs, abort pulse and timeout counter.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r      <= IDLE;
      sbc_clear    <= 1'b0;
      sbc_enable   <= 1'b0;
      enable_timer <= 1'b0;
      load_buffer  <= 1'b0;
      busy         <= 1'b0;
      timeout      <= 1'b0;
      tcnt_r       <= '0;
    end else begin
      state_r <= state_nx_s;
      {sbc_clear, sbc_enable, enable_timer, load_buffer} <= moore_dec(state_nx_s);
      busy    <= (state_nx_s != IDLE);
      timeout <= inc_tout_s;
      // RECEIVE is only ever entered from CLEAR, so zero the count there
      if (state_r == CLEAR) begin
        tcnt_r <= '0;
      end else if (state_r == RECEIVE) begin
        tcnt_r <= tcnt_r + TW'(1);
      end else begin
        tcnt_r <= tcnt_r;
      end
    end
  end

  // Packet, framing-error and timeout statistics; clear_stats wins over increments.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pkt_cnt  <= '0;
      ferr_cnt <= '0;
      tout_cnt <= '0;
    end else if (clear_stats) begin
      pkt_cnt  <= '0;
      ferr_cnt <= '0;
      tout_cnt <= '0;
    end else begin
      if (inc_pkt_s)  pkt_cnt  <= sat_inc(pkt_cnt);
      if (inc_ferr_s) ferr_cnt <= sat_inc(ferr_cnt);
      if (inc_tout_s) tout_cnt <= sat_inc(tout_cnt);
    end
  end

`ifdef RCU_PARITY_EN
  // Parity-error statistics; clear_stats wins over the increment.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      perr_cnt <= '0;
    end else if (clear_stats) begin
      perr_cnt <= '0;
    end else if ((state_r == CHECK) && parity_error) begin
      perr_cnt <= sat_inc(perr_cnt);
    end
  end
`else
  assign perr_cnt = '0;
`endif

endmodule

// File: tb/tb_rcu_param.sv
// Testbench for rcu_param (TIMEOUT_CYC=8, CNT_W=2). Packets are described as
// transactions; the expected per-cycle output waveform and statistics are
// derived from the packet description (receive length, errors, back-to-back).
module tb_rcu_param;

  localparam int T    = 8;
  localparam int W    = 2;
  localparam int MAXC = 3;
`ifdef RCU_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  // expected {sbc_clear, sbc_enable, enable_timer, load_buffer, busy, timeout}
  localparam logic [5:0] E_IDLE = 6'b000000;
  localparam logic [5:0] E_CLR  = 6'b100010;
  localparam logic [5:0] E_STOP = 6'b010010;
  localparam logic [5:0] E_RX   = 6'b001010;
  localparam logic [5:0] E_CHK  = 6'b000010;
  localparam logic [5:0] E_LD   = 6'b000110;
  localparam logic [5:0] E_TO   = 6'b000001;

  logic clk = 1'b0;
  logic n_rst, npd, pd, fe, pe, cs;
  logic sbc_clear, sbc_enable, enable_timer, load_buffer, busy, timeout;
  logic [W-1:0] pkt_cnt, ferr_cnt, perr_cnt, tout_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int m_pkt, m_ferr, m_perr, m_tout;

  rcu_param #(.TIMEOUT_CYC(T), .CNT_W(W)) dut (
    .clk(clk), .n_rst(n_rst), .new_packet_detected(npd), .packet_done(pd),
    .framing_error(fe), .parity_error(pe), .clear_stats(cs),
    .sbc_clear(sbc_clear), .sbc_enable(sbc_enable), .enable_timer(enable_timer),
    .load_buffer(load_buffer), .busy(busy), .timeout(timeout),
    .pkt_cnt(pkt_cnt), .ferr_cnt(ferr_cnt), .perr_cnt(perr_cnt), .tout_cnt(tout_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  function automatic int sat(int v);
    return (v >= MAXC) ? MAXC : v + 1;
  endfunction

  task automatic check_now(string name, logic [5:0] exp);
    logic [5:0] act;
    logic [4*W-1:0] ca, ce;
    act = {sbc_clear, sbc_enable, enable_timer, load_buffer, busy, timeout};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s flags: got %b want %b", name, act, exp);
    end
    ca = {pkt_cnt, ferr_cnt, perr_cnt, tout_cnt};
    ce = {W'(m_pkt), W'(m_ferr), W'(m_perr), W'(m_tout)};
    n_tests++;
    if (ca !== ce) begin
      n_fail++;
      $display("FAIL %s counters: got %h want %h", name, ca, ce);
    end
  endtask

  task automatic chk_cnt(string name, logic [W-1:0] act, int exp);
    n_tests++;
    if (act !== W'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // one clock: drive inputs at negedge, check at the next negedge
  task automatic step(string name, bit d_npd, bit d_pd, bit d_fe, bit d_pe, bit d_cs,
                      logic [5:0] exp, bit ip, bit ifr, bit ipr, bit ito);
    npd = d_npd; pd = d_pd; fe = d_fe; pe = d_pe; cs = d_cs;
    @(posedge clk);
    @(negedge clk);
    if (d_cs) begin
      m_pkt = 0; m_ferr = 0; m_perr = 0; m_tout = 0;
    end else begin
      if (ip)  m_pkt  = sat(m_pkt);
      if (ifr) m_ferr = sat(m_ferr);
      if (ipr) m_perr = sat(m_perr);
      if (ito) m_tout = sat(m_tout);
    end
    check_now(name, exp);
  endtask

  // idle gap then detection; leaves the DUT in CLEAR
  task automatic detect(int gap, bit rnd_cs);
    for (int i = 0; i < gap; i++)
      step("idle", 1'b0, rb(), rb(), rb(), rnd_cs && ($urandom_range(0, 7) == 0),
           E_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);
    step("detect", 1'b1, rb(), rb(), rb(), 1'b0, E_CLR, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // packet body from CLEAR; d > T means packet_done never comes
  task automatic pkt(int d, bit efe, bit epe, bit b2b, bit cs_chk, output bit in_clr);
    bit err;
    err    = efe | (PAR & epe);
    in_clr = 1'b0;
    step("clr2rx", rb(), rb(), rb(), rb(), 1'b0, E_RX, 1'b0, 1'b0, 1'b0, 1'b0);
    if (d > T) begin
      for (int i = 1; i < T; i++)
        step("rx_hold", rb(), 1'b0, rb(), rb(), 1'b0, E_RX, 1'b0, 1'b0, 1'b0, 1'b0);
      step("rx_timeout", rb(), 1'b0, rb(), rb(), 1'b0, E_TO, 1'b0, 1'b0, 1'b0, 1'b1);
      return;
    end
    for (int i = 1; i < d; i++)
      step("rx_hold", rb(), 1'b0, rb(), rb(), 1'b0, E_RX, 1'b0, 1'b0, 1'b0, 1'b0);
    step("rx_done", rb(), 1'b1, rb(), rb(), 1'b0, E_STOP, 1'b0, 1'b0, 1'b0, 1'b0);
    step("stop2chk", rb(), rb(), rb(), rb(), 1'b0, E_CHK, 1'b0, 1'b0, 1'b0, 1'b0);
    if (err) begin
      step("chk_drop", rb(), rb(), efe, epe, cs_chk, E_IDLE, 1'b0, efe, PAR & epe, 1'b0);
    end else begin
      step("chk_load", rb(), rb(), efe, epe, cs_chk, E_LD, 1'b1, 1'b0, 1'b0, 1'b0);
      step(b2b ? "ld2clr" : "ld2idle", b2b, rb(), rb(), rb(), 1'b0,
           b2b ? E_CLR : E_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);
      in_clr = b2b;
    end
  endtask

  typedef struct {
    int d; bit fe; bit pe; bit b2b;
    int x_pkt; int x_ferr; int x_perr; int x_tout;
  } vec_t;

  vec_t vt[8];

  initial begin
    bit in_clr;
    vt[0] = '{3,  1'b0, 1'b0, 1'b0, 1, 0, 0, 0};
    vt[1] = '{1,  1'b1, 1'b0, 1'b0, 1, 1, 0, 0};
    vt[2] = '{99, 1'b0, 1'b0, 1'b0, 1, 1, 0, 1};
    vt[3] = '{1,  1'b0, 1'b1, 1'b0, PAR ? 1 : 2, 1, PAR ? 1 : 0, 1};
    vt[4] = '{2,  1'b0, 1'b0, 1'b1, PAR ? 2 : 3, 1, PAR ? 1 : 0, 1};
    vt[5] = '{1,  1'b0, 1'b0, 1'b0, 3, 1, PAR ? 1 : 0, 1};
    vt[6] = '{8,  1'b0, 1'b0, 1'b0, 3, 1, PAR ? 1 : 0, 1};
    vt[7] = '{2,  1'b1, 1'b1, 1'b0, 3, 2, PAR ? 2 : 0, 1};

    // reset
    n_rst = 1'b0; npd = 1'b0; pd = 1'b0; fe = 1'b0; pe = 1'b0; cs = 1'b0;
    m_pkt = 0; m_ferr = 0; m_perr = 0; m_tout = 0;
    @(negedge clk); @(negedge clk);
    check_now("reset", E_IDLE);
    n_rst = 1'b1;
    step("post_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);

    // table of packet transactions with hand-computed statistics
    in_clr = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (!in_clr) detect(1, 1'b0);
      pkt(vt[k].d, vt[k].fe, vt[k].pe, vt[k].b2b, 1'b0, in_clr);
      chk_cnt("tbl_pkt",  pkt_cnt,  vt[k].x_pkt);
      chk_cnt("tbl_ferr", ferr_cnt, vt[k].x_ferr);
      chk_cnt("tbl_perr", perr_cnt, vt[k].x_perr);
      chk_cnt("tbl_tout", tout_cnt, vt[k].x_tout);
    end

    // reset in the middle of RECEIVE, then a normal packet
    detect(1, 1'b0);
    step("clr2rx", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_RX, 1'b0, 1'b0, 1'b0, 1'b0);
    step("rx_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_RX, 1'b0, 1'b0, 1'b0, 1'b0);
    n_rst = 1'b0;
    #1;
    m_pkt = 0; m_ferr = 0; m_perr = 0; m_tout = 0;
    check_now("mid_reset", E_IDLE);
    @(negedge clk); @(negedge clk);
    n_rst = 1'b1;
    detect(1, 1'b0);
    pkt(3, 1'b0, 1'b0, 1'b0, 1'b0, in_clr);
    chk_cnt("after_reset_pkt", pkt_cnt, 1);

    // framing-error saturation, then clear_stats against a sixth error
    for (int k = 0; k < 5; k++) begin
      detect(0, 1'b0);
      pkt(1, 1'b1, 1'b0, 1'b0, 1'b0, in_clr);
    end
    chk_cnt("ferr_sat", ferr_cnt, 3);
    detect(0, 1'b0);
    pkt(1, 1'b1, 1'b0, 1'b0, 1'b1, in_clr);
    chk_cnt("ferr_clear", ferr_cnt, 0);
    chk_cnt("pkt_clear", pkt_cnt, 0);

    // randomized packets
    in_clr = 1'b0;
    for (int k = 0; k < 150; k++) begin
      int  d;
      bit  efe, epe, b2b;
      d   = int'($urandom_range(1, T + 2));
      efe = ($urandom_range(0, 3) == 0);
      epe = ($urandom_range(0, 3) == 0);
      b2b = rb();
      if (!in_clr) detect(int'($urandom_range(0, 3)), 1'b1);
      pkt(d, efe, epe, b2b, ($urandom_range(0, 15) == 0), in_clr);
    end
    if (in_clr) begin
      pkt(1, 1'b0, 1'b0, 1'b0, 1'b0, in_clr);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
